alu_ctrl_muldiv_seq: RTL and testbench

//  Next-generation ALU controller for the RV32 execute stage.
//  - Base decode: ALUOp/Funct3/Funct7/ALUSrc -> 4-bit ALU Operation, same encoding as the base ALU.
//  - Adds the RV32M extension: detects MUL/DIV/REM and runs an iterative XLEN-wide multiply/divide unit.
//  - Stalls the pipeline until the M result is ready; EX result mux selects md_result when md_sel=1.

---
 rtl/alu_pkg.sv | 84 ++++++++
 rtl/md_iter_core.sv | 135 +++++++++++++
 rtl/alu_ctrl_muldiv_seq.sv | 106 ++++++++++
 tb/tb_alu_ctrl_muldiv_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types, Funct7 constants and base ALU decode for the
//                RV32 execute-stage ALU controller with M extension.
//  Revision    : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_LUI = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_XOR = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_BNE = 4'b1001,
        ALU_BLT = 4'b1010,
        ALU_BGE = 4'b1011,
        ALU_SLT = 4'b1100,
        ALU_SUB = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_JUMP   = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic alu_op_e alu_decode(input aluop_e aluop, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic alusrc);
        alu_op_e op;
        op = ALU_AND;
        case (aluop)
            ALUOP_MEM:    op = ALU_ADD;
            ALUOP_JUMP:   op = ALU_LUI;
            ALUOP_BRANCH: begin
                case (f3)
                    3'b000:  op = ALU_BEQ;
                    3'b001:  op = ALU_BNE;
                    3'b100:  op = ALU_BLT;
                    3'b101:  op = ALU_BGE;
                    default: op = ALU_AND;
                endcase
            end
            ALUOP_RTYPE: begin
                case (f3)
                    // SUB only exists in register form; ADDI with f7-like imm bits stays ADD
                    3'b000:  op = (f7 == F7_ALT && !alusrc) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = (f7 == F7_BASE) ? ALU_SRL : ((f7 == F7_ALT) ? ALU_SRA : ALU_AND);
                    3'b110:  op = ALU_OR;
                    3'b111:  op = ALU_AND;
                    default: op = ALU_AND;
                endcase
            end
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_core
//  Description : Iterative RV32M datapath: shift-add multiply / restoring divide
//                over a 2*XLEN accumulator, one step per cycle.
//  Revision    : 1.0
// ============================================================================
module md_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            fast
);

    localparam int              c_cw   = $clog2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;
    logic [c_cw-1:0]   r_cnt;
    md_op_e            r_op;
    logic              r_div;
    logic              r_neg;
    logic              r_bz;

    logic [XLEN-1:0]   w_a_abs, w_b_abs, w_a_in, w_b_in, w_fast_res, w_final;
    logic              w_neg, w_bz, w_ovf;
    logic [XLEN:0]     w_sum, w_rem_ext, w_diff;
    logic [2*XLEN-1:0] w_acc_nxt, w_prod;
    logic [XLEN-1:0]   w_q, w_r;

    assign w_a_abs = a[XLEN-1] ? -a : a;
    assign w_b_abs = b[XLEN-1] ? -b : b;
    assign w_bz    = (b == '0);
    assign w_ovf   = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign fast    = FAST_DIV0 && op[2] && (w_bz || w_ovf);
    assign w_fast_res = w_bz ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Signed ops run on magnitudes; w_neg records the sign to restore at the end
    always_comb begin
        w_a_in = a;
        w_b_in = b;
        w_neg  = 1'b0;
        case (md_op_e'(op))
            MD_MULH, MD_DIV: begin
                w_a_in = w_a_abs;
                w_b_in = w_b_abs;
                w_neg  = a[XLEN-1] ^ b[XLEN-1];
            end
            MD_MULHSU: begin
                w_a_in = w_a_abs;
                w_neg  = a[XLEN-1];
            end
            MD_REM: begin
                w_a_in = w_a_abs;
                w_b_in = w_b_abs;
                w_neg  = a[XLEN-1];
            end
            default: begin
                w_a_in = a;
                w_b_in = b;
                w_neg  = 1'b0;
            end
        endcase
    end

    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_rem_ext = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff    = w_rem_ext - {1'b0, r_b};
    assign w_acc_nxt = !r_div ? {w_sum, r_acc[XLEN-1:1]} :
                       (w_diff[XLEN] ? {w_rem_ext[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],    r_acc[XLEN-2:0], 1'b1});

    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_q    = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    assign w_r    = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_op)
            MD_MUL:                        w_final = w_acc_nxt[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               w_final = r_bz ? '1 : w_q;
            MD_REM, MD_REMU:               w_final = w_r;
            default:                       w_final = '0;
        endcase
    end

    assign done   = step && (r_cnt == c_last);
    assign result = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= MD_MUL;
            r_div    <= 1'b0;
            r_neg    <= 1'b0;
            r_bz     <= 1'b0;
        end else if (start) begin
            r_acc <= {{XLEN{1'b0}}, w_a_in};
            r_b   <= w_b_in;
            r_cnt <= '0;
            r_op  <= md_op_e'(op);
            r_div <= op[2];
            r_neg <= w_neg;
            r_bz  <= w_bz;
            if (fast) begin
                r_result <= w_fast_res;
            end
        end else if (step) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + c_cw'(1);
            if (done) begin
                r_result <= w_final;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_muldiv_seq
//  Description : RV32 ALU controller: base Operation decode plus RV32M issue,
//                stall and completion control around md_iter_core.
//  Revision    : 1.0
// ============================================================================
module alu_ctrl_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            ALUSrc,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            md_done,
    output logic            stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e  r_state, w_state_nxt;
    logic    w_is_md, w_start, w_step, w_stall;
    logic    w_core_done, w_core_fast;
    alu_op_e w_base_op;

    assign w_is_md   = valid_i && (ALUOp == ALUOP_RTYPE) && !ALUSrc && (Funct7 == F7_MULDIV);
    assign w_base_op = alu_decode(aluop_e'(ALUOp), Funct3, Funct7, ALUSrc);
    assign Operation = w_is_md ? ALU_ADD : w_base_op;
    assign md_sel    = w_is_md;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_md && !flush_i) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = w_core_fast ? S_DONE : S_BUSY;
                end
            end
            // valid_i is deliberately not consulted here: only a flush aborts
            S_BUSY: begin
                if (!flush_i) begin
                    w_step  = 1'b1;
                    w_stall = 1'b1;
                    if (w_core_done) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign md_done = (r_state == S_DONE) && !flush_i;
    assign stall_o = w_stall && !reset;

    md_iter_core #(
        .XLEN      (XLEN),
        .FAST_DIV0 (FAST_DIV0)
    ) u_core (
        .clk    (clk),
        .rst    (reset),
        .start  (w_start),
        .step   (w_step),
        .op     (Funct3),
        .a      (SrcA),
        .b      (SrcB),
        .result (md_result),
        .done   (w_core_done),
        .fast   (w_core_fast)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_muldiv_seq
//  Description : Self-checking bench for alu_ctrl_muldiv_seq (fast and full
//                iteration div-by-zero variants) against an arithmetic model.
//  Revision    : 1.0
// ============================================================================
module tb_alu_ctrl_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, valid_s, flush_i, ALUSrc;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;

    logic [3:0]  op_f, op_s;
    logic        sel_f, sel_s, done_f, done_s, stall_f, stall_s;
    logic [31:0] res_f, res_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv_seq #(.XLEN(32), .FAST_DIV0(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .ALUSrc(ALUSrc),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(op_f), .md_sel(sel_f),
        .md_result(res_f), .md_done(done_f), .stall_o(stall_f)
    );

    alu_ctrl_muldiv_seq #(.XLEN(32), .FAST_DIV0(1'b0)) dut_slow (
        .clk(clk), .reset(reset), .valid_i(valid_s), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .ALUSrc(ALUSrc),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(op_s), .md_sel(sel_s),
        .md_result(res_s), .md_done(done_s), .stall_o(stall_s)
    );

    function automatic logic [3:0] exp_op(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic src);
        if (aluop == 2'b00) return 4'b0010;
        if (aluop == 2'b11) return 4'b0011;
        if (aluop == 2'b01) begin
            if (f3 == 3'b000) return 4'b1000;
            if (f3 == 3'b001) return 4'b1001;
            if (f3 == 3'b100) return 4'b1010;
            if (f3 == 3'b101) return 4'b1011;
            return 4'b0000;
        end
        if (f3 == 3'b000) return (f7 == 7'h20 && !src) ? 4'b1111 : 4'b0010;
        if (f3 == 3'b001) return 4'b0100;
        if (f3 == 3'b010) return 4'b1100;
        if (f3 == 3'b100) return 4'b0110;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b101 && f7 == 7'h00) return 4'b0101;
        if (f3 == 3'b101 && f7 == 7'h20) return 4'b0111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ua = longint'({32'b0, a});
        longint     ub = longint'({32'b0, b});
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    task automatic go_idle();
        @(negedge clk);
        valid_i = 1'b0; valid_s = 1'b0; flush_i = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000; ALUSrc = 1'b0;
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit slow, input logic [31:0] exp, input string tag);
        int          exp_lat, cycles, stalls;
        bit          seen;
        logic        d, st;
        logic [31:0] r;
        exp_lat = (!slow && op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 &&
                   b == 32'hFFFF_FFFF))) ? 1 : 33;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = op; ALUSrc = 1'b0;
        SrcA = a; SrcB = b; flush_i = 1'b0;
        valid_i = !slow; valid_s = slow;
        #1;
        st = slow ? stall_s : stall_f;
        d  = slow ? done_s  : done_f;
        n_checks++;
        if (st !== 1'b1 || d !== 1'b0 || (slow ? op_s : op_f) !== 4'b0010 ||
            (slow ? sel_s : sel_f) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s issue: stall=%b done=%b required stall=1 done=0 Operation=0010 md_sel=1",
                     tag, st, d);
        end
        stalls = 1; cycles = 0; seen = 0; r = '0;
        while (!seen && cycles < 40) begin
            @(negedge clk); #1;
            cycles++;
            st = slow ? stall_s : stall_f;
            d  = slow ? done_s  : done_f;
            r  = slow ? res_s   : res_f;
            if (d === 1'b1) seen = 1;
            else if (st === 1'b1) stalls++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no md_done within 40 cycles, required at %0d", tag, exp_lat);
        end else begin
            n_checks++;
            if (cycles != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got T+%0d required T+%0d", tag, cycles, exp_lat);
            end
            n_checks++;
            if (r !== exp) begin
                n_fail++;
                $display("FAIL %s result: got %h required %h", tag, r, exp);
            end
            n_checks++;
            if (st !== 1'b0 || stalls != exp_lat) begin
                n_fail++;
                $display("FAIL %s stall: %0d stall cycles (stall at done=%b) required %0d",
                         tag, stalls, st, exp_lat);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_i = 1'b0; valid_s = 1'b0; flush_i = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'b000; ALUSrc = 1'b0;
        SrcA = 32'h0; SrcB = 32'h0;
        @(negedge clk); #1;
        n_checks++;
        if (done_f !== 1'b0 || stall_f !== 1'b0 || res_f !== 32'h0 || res_s !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: done=%b stall=%b res=%h res_s=%h required 0/0/0/0",
                     done_f, stall_f, res_f, res_s);
        end
        valid_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01;
        #1;
        n_checks++;
        if (stall_f !== 1'b0 || sel_f !== 1'b1 || op_f !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mop: stall=%b md_sel=%b op=%b required 0/1/0010",
                     stall_f, sel_f, op_f);
        end
        go_idle();
        reset = 1'b0;
    endtask

    task automatic test_decode();
        logic [6:0] f7s [4];
        logic [3:0] e;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
        @(negedge clk);
        valid_i = 1'b0;
        for (int al = 0; al < 4; al++) begin
            for (int f = 0; f < 8; f++) begin
                for (int k = 0; k < 4; k++) begin
                    for (int s = 0; s < 2; s++) begin
                        ALUOp = 2'(al); Funct3 = 3'(f); Funct7 = f7s[k]; ALUSrc = 1'(s);
                        #1;
                        e = exp_op(2'(al), 3'(f), f7s[k], 1'(s));
                        n_checks++;
                        if (op_f !== e || sel_f !== 1'b0 || stall_f !== 1'b0) begin
                            n_fail++;
                            $display("FAIL decode aluop=%0d f3=%0d f7=%h src=%0d: op=%b sel=%b stall=%b required %b/0/0",
                                     al, f, f7s[k], s, op_f, sel_f, stall_f, e);
                        end
                    end
                end
            end
        end
        // M-op overrides Operation; flush in IDLE keeps it from issuing
        valid_i = 1'b1; ALUOp = 2'b10; Funct7 = 7'h01; ALUSrc = 1'b0; Funct3 = 3'b111;
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (op_f !== 4'b0010 || sel_f !== 1'b1 || stall_f !== 1'b0) begin
            n_fail++;
            $display("FAIL mop_flush_idle: op=%b sel=%b stall=%b required 0010/1/0", op_f, sel_f, stall_f);
        end
        @(negedge clk); #1;
        n_checks++;
        if (done_f !== 1'b0 || stall_f !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_hold: done=%b stall=%b required 0/0", done_f, stall_f);
        end
        ALUSrc = 1'b1; flush_i = 1'b0;
        #1;
        n_checks++;
        if (sel_f !== 1'b0 || stall_f !== 1'b0 || op_f !== 4'b0000) begin
            n_fail++;
            $display("FAIL itype_not_md: sel=%b stall=%b op=%b required 0/0/0000", sel_f, stall_f, op_f);
        end
        go_idle();
    endtask

    task automatic test_spec_vectors();
        run_md(3'd0, 32'd7,          32'hFFFF_FFFD, 0, 32'hFFFF_FFEB, "mul_7_m3");
        run_md(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, "mulhu_max");
        run_md(3'd4, 32'hFFFF_FFF9,  32'd2,         0, 32'hFFFF_FFFD, "div_m7_2");
        run_md(3'd6, 32'hFFFF_FFF9,  32'd2,         0, 32'hFFFF_FFFF, "rem_m7_2");
        run_md(3'd5, 32'd100,        32'd7,         0, 32'h0000_000E, "divu_100_7");
        run_md(3'd7, 32'd100,        32'd7,         0, 32'h0000_0002, "remu_100_7");
        run_md(3'd4, 32'h1234_5678,  32'd0,         0, 32'hFFFF_FFFF, "div_by0");
        run_md(3'd6, 32'd5,          32'd0,         0, 32'd5,         "rem_5_0");
        run_md(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, "div_ovf");
        run_md(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h0,         "rem_ovf");
        go_idle();
    endtask

    task automatic test_slow_div0();
        run_md(3'd4, 32'hFFFF_FFF0,  32'd0,         1, 32'hFFFF_FFFF, "slow_div_neg_by0");
        run_md(3'd6, 32'hFFFF_FFF0,  32'd0,         1, 32'hFFFF_FFF0, "slow_rem_neg_by0");
        run_md(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, "slow_div_ovf");
        run_md(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h0,         "slow_rem_ovf");
        run_md(3'd5, 32'd9,          32'd0,         1, 32'hFFFF_FFFF, "slow_divu_by0");
        go_idle();
    endtask

    task automatic test_flush();
        int hits;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; ALUSrc = 1'b0;
        SrcA = 32'd12345; SrcB = 32'd678; valid_i = 1'b1;
        for (int i = 0; i < 11; i++) @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (stall_f !== 1'b0 || done_f !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: stall=%b done=%b required 0/0", stall_f, done_f);
        end
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done_f !== 1'b0 || stall_f !== 1'b0) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL flush_aftermath: %0d cycles with done/stall, required 0", hits);
        end
        run_md(3'd0, 32'd3, 32'd4, 0, 32'h0000_000C, "mul_after_flush");
        go_idle();
    endtask

    task automatic test_valid_drop();
        logic [31:0] a, b, e;
        int          cycles;
        bit          seen;
        a = $urandom; b = $urandom_range(1, 65535);
        e = ref_md(3'd5, a, b);
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd5; ALUSrc = 1'b0;
        SrcA = a; SrcB = b; valid_i = 1'b1;
        cycles = 0; seen = 0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            if (cycles == 2) valid_i = 1'b0;
            #1;
            cycles++;
            if (done_f === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || cycles != 33 || res_f !== e) begin
            n_fail++;
            $display("FAIL valid_drop: seen=%0d at T+%0d result %h required T+33 %h",
                     seen, cycles, res_f, e);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; ALUSrc = 1'b0;
        SrcA = 32'd99; SrcB = 32'd77; valid_i = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (res_f !== 32'h0 || done_f !== 1'b0 || stall_f !== 1'b0 || sel_f !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: res=%h done=%b stall=%b sel=%b required 0/0/0/1",
                     res_f, done_f, stall_f, sel_f);
        end
        go_idle();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_md(3'd0, 32'd3,  32'd4, 0, 32'h0000_000C, "b2b_mul");
        run_md(3'd5, 32'd10, 32'd3, 0, 32'h0000_0003, "b2b_divu");
        go_idle();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_md(op, a, b, 0, ref_md(op, a, b), $sformatf("rand%0d_op%0d", i, op));
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_spec_vectors();
        test_slow_div0();
        test_flush();
        test_valid_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
